// File: rtl/dnu_iter_ctrl.sv
// Iteration controller for the degree-3 DNU write path: sequences one write-FSM
// request per decoding iteration and decides convergence, iteration limit, abort or timeout.
module dnu_iter_ctrl #(
  parameter int MAX_ITER    = 10,
  parameter int ITER_WIDTH  = 4,
  parameter int WDOG_CYCLES = 256
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  input  logic                  dec_start,
  input  logic                  dec_abort,
  input  logic                  syndrome_ok,
  input  logic [1:0]            wr_busy,
  output logic                  iter_rqst,
  output logic                  iter_termination,
  output logic [ITER_WIDTH-1:0] iter_idx,
  output logic                  dec_done,
  output logic                  dec_converged,
  output logic                  wdog_err,
  output logic [2:0]            ctrl_state
);

  localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_RQST    = 3'b001,
    ST_RELEASE = 3'b010,
    ST_EVAL    = 3'b011,
    ST_TERM    = 3'b100
  } state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        wdog_cnt_r;
  logic [ITER_WIDTH-1:0]   iter_idx_r;
  logic                    conv_r, wdog_err_r;
  logic                    start_s, inc_s, conv_set_s, conv_clr_s, err_set_s;
  logic                    wdog_exp_s, busy_fin_s, busy_idle_s, last_iter_s;

  // wr_busy==11 matches neither code, so it behaves like "updating"
  assign busy_fin_s  = (wr_busy == 2'b10);
  assign busy_idle_s = (wr_busy == 2'b00);
  assign wdog_exp_s  = (wdog_cnt_r == CNT_W'(WDOG_CYCLES - 1));
  assign last_iter_s = (iter_idx_r == ITER_WIDTH'(MAX_ITER - 1));

  // Next-state decode; exit conditions are tested before the watchdog so they win ties
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    inc_s      = 1'b0;
    conv_set_s = 1'b0;
    conv_clr_s = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dec_start) begin
          state_s = ST_RQST;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RQST: begin
        if (dec_abort) begin
          state_s = ST_TERM;
        end else if (busy_fin_s) begin
          state_s = ST_RELEASE;
        end else if (wdog_exp_s) begin
          state_s   = ST_TERM;
          err_set_s = 1'b1;
        end else begin
          state_s = ST_RQST;
        end
      end
      ST_RELEASE: begin
        if (dec_abort) begin
          state_s = ST_TERM;
        end else if (busy_idle_s) begin
          state_s = ST_EVAL;
        end else if (wdog_exp_s) begin
          state_s   = ST_TERM;
          err_set_s = 1'b1;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      ST_EVAL: begin
        if (dec_abort) begin
          state_s = ST_TERM;
        end else if (syndrome_ok) begin
          state_s    = ST_TERM;
          conv_set_s = 1'b1;
        end else if (last_iter_s) begin
          state_s    = ST_TERM;
          conv_clr_s = 1'b1;
        end else begin
          state_s = ST_RQST;
          inc_s   = 1'b1;
        end
      end
      ST_TERM: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Watchdog: restarts on every state change, counts only while waiting on the write FSM
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      wdog_cnt_r <= '0;
    end else if (state_s != state_r) begin
      wdog_cnt_r <= '0;
    end else if (state_r == ST_RQST || state_r == ST_RELEASE) begin
      wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
    end else begin
      wdog_cnt_r <= '0;
    end
  end

  // Iteration index and result flags; only EVAL may advance the ROM page
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      iter_idx_r <= '0;
      conv_r     <= 1'b0;
      wdog_err_r <= 1'b0;
    end else if (start_s) begin
      iter_idx_r <= '0;
      conv_r     <= 1'b0;
      wdog_err_r <= 1'b0;
    end else begin
      if (inc_s) begin
        iter_idx_r <= iter_idx_r + ITER_WIDTH'(1);
      end
      if (conv_set_s) begin
        conv_r <= 1'b1;
      end else if (conv_clr_s) begin
        conv_r <= 1'b0;
      end
      if (err_set_s) begin
        wdog_err_r <= 1'b1;
      end
    end
  end

  assign iter_rqst        = (state_r == ST_RQST);
  assign iter_termination = (state_r == ST_TERM);
  assign dec_done         = (state_r == ST_TERM);
  assign iter_idx         = iter_idx_r;
  assign dec_converged    = conv_r;
  assign wdog_err         = wdog_err_r;
  assign ctrl_state       = state_r;

endmodule

// File: tb/tb_dnu_iter_ctrl.sv
// Self-checking bench for dnu_iter_ctrl: vector table, directed multi-cycle corners,
// and randomized stimulus against a cycle-level reference model.
module tb_dnu_iter_ctrl;

  localparam int MAX_ITER = 10;
  localparam int ITER_W   = 4;
  localparam int WDOG     = 256;

  localparam int S_IDLE = 0, S_RQST = 1, S_REL = 2, S_EVAL = 3, S_TERM = 4;

  logic              write_clk, rstn;
  logic              dec_start, dec_abort, syndrome_ok;
  logic [1:0]        wr_busy;
  logic              iter_rqst, iter_termination, dec_done, dec_converged, wdog_err;
  logic [ITER_W-1:0] iter_idx;
  logic [2:0]        ctrl_state;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_state, m_idx, m_wd;
  bit m_conv, m_err;

  // behavioural write FSM
  int wf_ph, wf_cnt;

  dnu_iter_ctrl #(.MAX_ITER(MAX_ITER), .ITER_WIDTH(ITER_W), .WDOG_CYCLES(WDOG)) dut (
    .write_clk(write_clk), .rstn(rstn), .dec_start(dec_start), .dec_abort(dec_abort),
    .syndrome_ok(syndrome_ok), .wr_busy(wr_busy), .iter_rqst(iter_rqst),
    .iter_termination(iter_termination), .iter_idx(iter_idx), .dec_done(dec_done),
    .dec_converged(dec_converged), .wdog_err(wdog_err), .ctrl_state(ctrl_state)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {ctrl_state, iter_idx, iter_rqst, iter_termination, dec_done, dec_converged, wdog_err};
  endfunction

  function automatic logic [11:0] model_out();
    return {3'(m_state), 4'(m_idx), m_state == S_RQST, m_state == S_TERM, m_state == S_TERM,
            m_conv, m_err};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_idx = 0; m_wd = 0; m_conv = 0; m_err = 0;
  endtask

  // One clock of the controller's rules, from the inputs present before the edge
  task automatic model_step();
    int  nxt;
    bit  waiting, expired;
    nxt     = m_state;
    waiting = (m_state == S_RQST) || (m_state == S_REL);
    expired = waiting && (m_wd == WDOG - 1);
    if (m_state == S_IDLE) begin
      if (dec_start) begin nxt = S_RQST; m_idx = 0; m_conv = 0; m_err = 0; end
    end else if (m_state == S_TERM) begin
      nxt = S_IDLE;
    end else if (m_state == S_EVAL) begin
      if (dec_abort) nxt = S_TERM;
      else if (syndrome_ok) begin nxt = S_TERM; m_conv = 1; end
      else if (m_idx == MAX_ITER - 1) begin nxt = S_TERM; m_conv = 0; end
      else begin nxt = S_RQST; m_idx = m_idx + 1; end
    end else begin
      if (dec_abort) nxt = S_TERM;
      else if (m_state == S_RQST && wr_busy == 2'b10) nxt = S_REL;
      else if (m_state == S_REL && wr_busy == 2'b00) nxt = S_EVAL;
      else if (expired) begin nxt = S_TERM; m_err = 1; end
    end
    m_wd    = (nxt == m_state && waiting) ? m_wd + 1 : 0;
    m_state = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge write_clk);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic idle_inputs();
    dec_start = 0; dec_abort = 0; syndrome_ok = 0; wr_busy = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    model_reset();
    repeat (2) @(posedge write_clk);
    #1 check("reset_outputs", dut_out(), 12'h000);
    @(negedge write_clk) rstn = 1;
  endtask

  // write FSM model: ~67-cycle iterations, holds FINISH until the request drops
  task automatic wfsm_update();
    case (wf_ph)
      0: if (iter_rqst) begin wf_ph = 1; wf_cnt = 0; end
      1: begin wf_cnt++; if (wf_cnt >= 65) wf_ph = 2; end
      2: if (!iter_rqst) wf_ph = 0;
      default: wf_ph = 0;
    endcase
    wr_busy = (wf_ph == 1) ? 2'b01 : (wf_ph == 2) ? 2'b10 : 2'b00;
  endtask

  task automatic run_codeword(input int conv_at, input int exp_reqs, input int exp_idx,
                              input logic exp_conv, input string tag);
    int reqs, dones, terms, evals, cyc, last_idx;
    logic prev;
    reqs = 0; dones = 0; terms = 0; evals = 0; cyc = 0; last_idx = -1; prev = 0;
    idle_inputs();
    wf_ph = 0;
    dec_start = 1;
    tick();
    dec_start = 0;
    while (cyc < 2000) begin
      if (iter_rqst && !prev) begin
        check({tag, "_req_idx"}, 32'(iter_idx), 32'(reqs));
        reqs++;
      end
      prev = iter_rqst;
      if (dec_done) begin dones++; last_idx = int'(iter_idx); end
      if (iter_termination) terms++;
      if (dones > 0 && ctrl_state == 3'b000) break;
      wfsm_update();
      syndrome_ok = (m_state == S_EVAL) && (evals == conv_at);
      if (m_state == S_EVAL) evals++;
      tick();
      cyc++;
    end
    check({tag, "_bounded"}, 32'(cyc < 2000), 32'd1);
    check({tag, "_requests"}, 32'(reqs), 32'(exp_reqs));
    check({tag, "_final_idx"}, 32'(last_idx), 32'(exp_idx));
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_term_cycles"}, 32'(terms), 32'd1);
    check({tag, "_converged"}, 32'(dec_converged), 32'(exp_conv));
  endtask

  typedef struct {
    logic       start, abort, synd;
    logic [1:0] busy;
    logic [2:0] st;
    logic [3:0] idx;
    logic       rqst, term, done, conv, err;
  } vec_t;

  function automatic vec_t mk(logic s, logic a, logic y, logic [1:0] b, logic [2:0] st,
                              logic [3:0] ix, logic r, logic t, logic d, logic c, logic e);
    vec_t v;
    v.start = s; v.abort = a; v.synd = y; v.busy = b; v.st = st; v.idx = ix;
    v.rqst = r; v.term = t; v.done = d; v.conv = c; v.err = e;
    return v;
  endfunction

  vec_t vecs[23];

  initial begin
    int k;
    //            st  ab sy busy   state  idx  rq tm dn cv er
    vecs[0]  = mk(1, 0, 0, 2'b00, 3'b001, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 2'b01, 3'b001, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 2'b11, 3'b001, 0, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 2'b00, 3'b011, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 2'b00, 3'b001, 1, 1, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 2'b01, 3'b001, 1, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 2'b10, 3'b010, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 2'b00, 3'b011, 1, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 2'b00, 3'b100, 1, 0, 1, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 2'b00, 3'b000, 1, 0, 0, 0, 1, 0);
    vecs[13] = mk(0, 1, 0, 2'b00, 3'b000, 1, 0, 0, 0, 1, 0);
    vecs[14] = mk(1, 0, 0, 2'b00, 3'b001, 0, 1, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 2'b01, 3'b100, 0, 0, 1, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 2'b00, 3'b001, 0, 1, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 2'b00, 3'b011, 0, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 1, 1, 2'b00, 3'b100, 0, 0, 1, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0);

    wf_ph = 0; wf_cnt = 0;
    do_reset();

    foreach (vecs[i]) begin
      dec_start = vecs[i].start; dec_abort = vecs[i].abort;
      syndrome_ok = vecs[i].synd; wr_busy = vecs[i].busy;
      tick();
      check($sformatf("vec%0d", i), dut_out(),
            {vecs[i].st, vecs[i].idx, vecs[i].rqst, vecs[i].term, vecs[i].done,
             vecs[i].conv, vecs[i].err});
    end

    // asynchronous reset while requesting
    idle_inputs();
    dec_start = 1;
    tick();
    dec_start = 0;
    #2 rstn = 0;
    #1 check("async_reset_now", dut_out(), 12'h000);
    model_reset();
    @(negedge write_clk) rstn = 1;
    dec_start = 1;
    tick();
    dec_start = 0;
    check("start_after_reset", 32'(iter_rqst), 32'd1);
    dec_abort = 1; tick(); dec_abort = 0; tick();

    run_codeword(2, 3, 2, 1'b1, "converge");
    run_codeword(-1, MAX_ITER, MAX_ITER - 1, 1'b0, "limit");

    // watchdog with the write FSM stuck updating
    idle_inputs();
    dec_start = 1; tick(); dec_start = 0;
    wr_busy = 2'b01;
    k = 0;
    while (ctrl_state != 3'b100 && k < 400) begin tick(); k++; end
    check("wdog_cycles", 32'(k), 32'(WDOG));
    check("wdog_err_set", 32'(wdog_err), 32'd1);
    wr_busy = 2'b00;
    repeat (3) tick();
    check("wdog_err_sticky", {ctrl_state, wdog_err}, {3'b000, 1'b1});
    dec_start = 1; tick(); dec_start = 0;
    check("wdog_err_cleared", {ctrl_state, wdog_err}, {3'b001, 1'b0});

    // FINISH arriving on the expiry edge must win
    wr_busy = 2'b01;
    repeat (WDOG - 1) tick();
    wr_busy = 2'b10;
    tick();
    check("tie_release", {ctrl_state, wdog_err}, {3'b010, 1'b0});
    dec_abort = 1; wr_busy = 2'b01; tick(); dec_abort = 0; tick();

    // randomized stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      dec_start   = ($urandom_range(0, 99) < 20);
      dec_abort   = ($urandom_range(0, 99) < 3);
      syndrome_ok = ($urandom_range(0, 99) < 30);
      r = $urandom_range(0, 9);
      wr_busy = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
